// File: rtl/core_mem_pkg.sv
// -----------------------------------------------------------------------------
// core_mem_pkg
//
// Shared types and default widths for the core's memory-side blocks.
//
// Contents:
//   DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH - default bus widths (32 bits)
//   arb_state_t   - arbiter state: IDLE, BUSY_INST, BUSY_DATA
//   requester_t   - identifies a requester: REQ_INST, REQ_DATA
//   busy_state_of - maps a requester to the BUSY state that serves it
// -----------------------------------------------------------------------------
package core_mem_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_INST = 2'd1,
        BUSY_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } requester_t;

    // The state that owns the memory port while serving 'req'.
    function automatic arb_state_t busy_state_of(input requester_t req);
        return (req == REQ_DATA) ? BUSY_DATA : BUSY_INST;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//
// Combinational winner selection between an instruction requester and a
// data requester. Kept separate so later multi-port arbiters can reuse the
// same selection rule.
//
// Parameters:
//   DATA_PRIORITY - 1: data always wins a conflict.
//                   0: round-robin, the requester that was not granted last
//                      wins a conflict.
//
// Ports:
//   inst_valid  in   instruction requester has a pending request
//   data_valid  in   data requester has a pending request
//   last_grant  in   requester that completed the most recent transfer
//   any_valid   out  at least one request is pending
//   winner      out  requester to grant (only meaningful when any_valid)
// -----------------------------------------------------------------------------
module arb_pick
    import core_mem_pkg::*;
#(
    parameter int DATA_PRIORITY = 1
) (
    input  logic       inst_valid,
    input  logic       data_valid,
    input  requester_t last_grant,
    output logic       any_valid,
    output requester_t winner
);

    always_comb begin
        any_valid = inst_valid | data_valid;
        winner    = REQ_INST;
        if (inst_valid && data_valid) begin
            if (DATA_PRIORITY != 0) begin
                winner = REQ_DATA;
            end else begin
                // Conflict under round-robin: hand the port to whoever did
                // not have it last time.
                winner = (last_grant == REQ_INST) ? REQ_DATA : REQ_INST;
            end
        end else if (data_valid) begin
            winner = REQ_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction fetcher and the
// load/store unit. A request is granted one cycle after its valid is seen in
// IDLE; the grant is then locked until the memory signals ready. Ready and
// read data are forwarded only to the granted requester, in the same cycle
// the memory returns them. Every completed transfer is followed by at least
// one IDLE cycle.
//
// Handshake (all three ports): the requester raises valid with its address
// (and store fields) and holds them stable until ready. Ready is a one-cycle
// pulse that both completes the transfer and marks read data as valid.
// A requester may not withdraw a request; once granted, the transaction
// stays open until the memory's ready. The memory's ready is ignored when no
// request is outstanding.
//
// Optional build macro:
//   MEM_PORT_ARBITER_PERF_EN - adds per-requester wait-cycle counters
//                              (inst_wait_cycles, data_wait_cycles).
//
// Parameters:
//   ADDR_WIDTH    - address width on all ports
//   DATA_WIDTH    - data width, multiple of 8
//   DATA_PRIORITY - 1: data wins conflicts; 0: round-robin on conflicts
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inst_in_addr/valid         fetch request
//   inst_in_data/ready         fetch read data / completion
//   data_in_addr/wdata/we/wstrb/valid   load/store request
//   data_in_rdata/ready        load read data / completion
//   mem_out_addr/wdata/we/wstrb/valid   memory request
//   mem_out_data/ready         memory read data / completion
//   dbg_state                  current arbiter state, for observation
//   inst_wait_cycles           (PERF_EN) cycles fetch waited for ready
//   data_wait_cycles           (PERF_EN) cycles load/store waited for ready
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   inst_in_addr,
    input  logic                    inst_in_valid,
    output logic [DATA_WIDTH-1:0]   inst_in_data,
    output logic                    inst_in_ready,

    input  logic [ADDR_WIDTH-1:0]   data_in_addr,
    input  logic [DATA_WIDTH-1:0]   data_in_wdata,
    input  logic                    data_in_we,
    input  logic [DATA_WIDTH/8-1:0] data_in_wstrb,
    input  logic                    data_in_valid,
    output logic [DATA_WIDTH-1:0]   data_in_rdata,
    output logic                    data_in_ready,

    output logic [ADDR_WIDTH-1:0]   mem_out_addr,
    output logic [DATA_WIDTH-1:0]   mem_out_wdata,
    output logic                    mem_out_we,
    output logic [DATA_WIDTH/8-1:0] mem_out_wstrb,
    output logic                    mem_out_valid,
    input  logic [DATA_WIDTH-1:0]   mem_out_data,
    input  logic                    mem_out_ready,

    output arb_state_t              dbg_state
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]             inst_wait_cycles,
    output logic [31:0]             data_wait_cycles
`endif
);

    // -------------------------------------------------------------------------
    // Arbitration state
    // -------------------------------------------------------------------------
    arb_state_t state_q;
    arb_state_t state_d;
    requester_t last_grant_q;
    requester_t last_grant_d;

    logic       pick_any;
    requester_t pick_winner;

    arb_pick #(
        .DATA_PRIORITY (DATA_PRIORITY)
    ) u_arb_pick (
        .inst_valid (inst_in_valid),
        .data_valid (data_in_valid),
        .last_grant (last_grant_q),
        .any_valid  (pick_any),
        .winner     (pick_winner)
    );

    // State register. last_grant resets to INST so that data wins the very
    // first conflict under round-robin as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_INST;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic. The grant is only evaluated in IDLE, which is what
    // forces the idle cycle between back-to-back transfers.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = busy_state_of(pick_winner);
                end
            end
            BUSY_INST: begin
                if (mem_out_ready) begin
                    state_d      = IDLE;
                    last_grant_d = REQ_INST;
                end
            end
            BUSY_DATA: begin
                if (mem_out_ready) begin
                    state_d      = IDLE;
                    last_grant_d = REQ_DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Everything is a function of the registered state plus
    // the live request/response signals, so ready reaches the granted
    // requester in the same cycle the memory returns it. Read-data outputs
    // are forced to zero outside their ready cycle.
    always_comb begin
        mem_out_valid = 1'b0;
        mem_out_addr  = '0;
        mem_out_wdata = '0;
        mem_out_we    = 1'b0;
        mem_out_wstrb = '0;
        inst_in_ready = 1'b0;
        inst_in_data  = '0;
        data_in_ready = 1'b0;
        data_in_rdata = '0;
        case (state_q)
            BUSY_INST: begin
                // Fetches are always reads: store fields stay at zero.
                mem_out_valid = 1'b1;
                mem_out_addr  = inst_in_addr;
                inst_in_ready = mem_out_ready;
                if (mem_out_ready) begin
                    inst_in_data = mem_out_data;
                end
            end
            BUSY_DATA: begin
                mem_out_valid = 1'b1;
                mem_out_addr  = data_in_addr;
                mem_out_wdata = data_in_wdata;
                mem_out_we    = data_in_we;
                mem_out_wstrb = data_in_wstrb;
                data_in_ready = mem_out_ready;
                if (mem_out_ready) begin
                    data_in_rdata = mem_out_data;
                end
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = state_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
    // -------------------------------------------------------------------------
    // Wait-cycle counters: one count per cycle a requester has valid high
    // without ready. They saturate rather than wrap so a long run never
    // reports a misleadingly small figure.
    // -------------------------------------------------------------------------
    localparam logic [31:0] WAIT_MAX = 32'hFFFF_FFFF;

    logic [31:0] inst_wait_q;
    logic [31:0] inst_wait_d;
    logic [31:0] data_wait_q;
    logic [31:0] data_wait_d;

    always_comb begin
        inst_wait_d = inst_wait_q;
        data_wait_d = data_wait_q;
        if (inst_in_valid && !inst_in_ready && (inst_wait_q != WAIT_MAX)) begin
            inst_wait_d = inst_wait_q + 32'd1;
        end
        if (data_in_valid && !data_in_ready && (data_wait_q != WAIT_MAX)) begin
            data_wait_d = data_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_wait_q <= '0;
            data_wait_q <= '0;
        end else begin
            inst_wait_q <= inst_wait_d;
            data_wait_q <= data_wait_d;
        end
    end

    assign inst_wait_cycles = inst_wait_q;
    assign data_wait_cycles = data_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters side by side: index 0 is built with DATA_PRIORITY=1, index 1
// with DATA_PRIORITY=0. Each has its own requester drivers and memory
// responder. A transfer-level model tracks which requester owns each port
// and predicts ready, read data, memory-side fields and wait counters.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import core_mem_pkg::*;

    localparam int OWN_NONE = 0;
    localparam int OWN_INST = 1;
    localparam int OWN_DATA = 2;
    localparam logic [31:0] SAT = 32'hFFFF_FFFF;

    // ---------------------------------------------------------------- clock
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------- signals
    logic        rst        [2];
    logic [31:0] inst_addr  [2];
    logic        inst_valid [2];
    logic [31:0] inst_rdata [2];
    logic        inst_ready [2];
    logic [31:0] data_addr  [2];
    logic [31:0] data_wdata [2];
    logic        data_we    [2];
    logic [3:0]  data_wstrb [2];
    logic        data_valid [2];
    logic [31:0] data_rdata [2];
    logic        data_ready [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic        mem_we     [2];
    logic [3:0]  mem_wstrb  [2];
    logic        mem_valid  [2];
    logic [31:0] mem_rdata  [2];
    logic        mem_ready  [2];
    arb_state_t  dbg_state  [2];
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] inst_wait  [2];
    logic [31:0] data_wait  [2];
`endif

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(1)) dut_fixed (
        .clk(clk), .reset(rst[0]),
        .inst_in_addr(inst_addr[0]), .inst_in_valid(inst_valid[0]),
        .inst_in_data(inst_rdata[0]), .inst_in_ready(inst_ready[0]),
        .data_in_addr(data_addr[0]), .data_in_wdata(data_wdata[0]),
        .data_in_we(data_we[0]), .data_in_wstrb(data_wstrb[0]),
        .data_in_valid(data_valid[0]), .data_in_rdata(data_rdata[0]),
        .data_in_ready(data_ready[0]),
        .mem_out_addr(mem_addr[0]), .mem_out_wdata(mem_wdata[0]),
        .mem_out_we(mem_we[0]), .mem_out_wstrb(mem_wstrb[0]),
        .mem_out_valid(mem_valid[0]), .mem_out_data(mem_rdata[0]),
        .mem_out_ready(mem_ready[0]),
        .dbg_state(dbg_state[0])
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .inst_wait_cycles(inst_wait[0]), .data_wait_cycles(data_wait[0])
`endif
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(0)) dut_rr (
        .clk(clk), .reset(rst[1]),
        .inst_in_addr(inst_addr[1]), .inst_in_valid(inst_valid[1]),
        .inst_in_data(inst_rdata[1]), .inst_in_ready(inst_ready[1]),
        .data_in_addr(data_addr[1]), .data_in_wdata(data_wdata[1]),
        .data_in_we(data_we[1]), .data_in_wstrb(data_wstrb[1]),
        .data_in_valid(data_valid[1]), .data_in_rdata(data_rdata[1]),
        .data_in_ready(data_ready[1]),
        .mem_out_addr(mem_addr[1]), .mem_out_wdata(mem_wdata[1]),
        .mem_out_we(mem_we[1]), .mem_out_wstrb(mem_wstrb[1]),
        .mem_out_valid(mem_valid[1]), .mem_out_data(mem_rdata[1]),
        .mem_out_ready(mem_ready[1]),
        .dbg_state(dbg_state[1])
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .inst_wait_cycles(inst_wait[1]), .data_wait_cycles(data_wait[1])
`endif
    );

    // --------------------------------------------------- model / bookkeeping
    int          owner     [2];   // who holds the memory port
    int          last      [2];   // who completed the previous transfer
    logic        m_ir      [2];   // predicted inst ready this cycle
    logic        m_dr      [2];   // predicted data ready this cycle
    logic [31:0] m_wait_i  [2];
    logic [31:0] m_wait_d  [2];

    int          mcnt      [2];   // memory responder: cycles into request
    int          mlat      [2];
    logic [31:0] mval      [2];
    int          lat_inst  [2];   // <0 means random latency
    int          lat_data  [2];
    logic        fixed_en  [2];
    logic [31:0] fixed_val [2];
    logic        keep      [2];   // reissue immediately after each ready

    int          inst_done_cnt [2];
    int          data_done_cnt [2];
    int          glog      [2][16];
    int          gcnt      [2];
    logic [31:0] rec_irdata [2];
    logic [31:0] rec_addr  [2];
    logic [31:0] rec_wdata [2];
    logic        rec_we    [2];
    logic [3:0]  rec_wstrb [2];

    int total;
    int bad;

    // ----------------------------------------------------------- scoreboard
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input int p, input string s);
        return $sformatf("p%0d_%s", p, s);
    endfunction

    function automatic arb_state_t exp_state(input int o);
        if (o == OWN_INST) return BUSY_INST;
        if (o == OWN_DATA) return BUSY_DATA;
        return IDLE;
    endfunction

    // --------------------------------------------------------- cycle driver
    // One clock: advance the model with the values present at the edge, let
    // the memory respond, then check every output and update requesters.
    task automatic cycle();
        int lat;
        for (int p = 0; p < 2; p++) begin
            if (rst[p]) begin
                owner[p]    = OWN_NONE;
                last[p]     = OWN_INST;
                m_wait_i[p] = '0;
                m_wait_d[p] = '0;
            end else begin
                if (inst_valid[p] && !m_ir[p] && m_wait_i[p] != SAT) m_wait_i[p] = m_wait_i[p] + 32'd1;
                if (data_valid[p] && !m_dr[p] && m_wait_d[p] != SAT) m_wait_d[p] = m_wait_d[p] + 32'd1;
                if (owner[p] != OWN_NONE) begin
                    if (m_ir[p] || m_dr[p]) begin
                        last[p]  = owner[p];
                        owner[p] = OWN_NONE;
                    end
                end else if (inst_valid[p] && data_valid[p]) begin
                    // Port 0 favours data; port 1 alternates.
                    if (p == 0) owner[p] = OWN_DATA;
                    else        owner[p] = (last[p] == OWN_DATA) ? OWN_INST : OWN_DATA;
                end else if (data_valid[p]) begin
                    owner[p] = OWN_DATA;
                end else if (inst_valid[p]) begin
                    owner[p] = OWN_INST;
                end
            end
        end

        @(posedge clk);
        #1;

        for (int p = 0; p < 2; p++) begin
            if (!mem_valid[p]) begin
                mcnt[p]      = 0;
                mem_ready[p] = 1'b0;
                mem_rdata[p] = $urandom;
            end else begin
                if (mcnt[p] == 0) begin
                    lat      = (owner[p] == OWN_INST) ? lat_inst[p] : lat_data[p];
                    mlat[p]  = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
                    mval[p]  = fixed_en[p] ? fixed_val[p] : $urandom;
                end
                mcnt[p]++;
                mem_ready[p] = (mcnt[p] > mlat[p]);
                mem_rdata[p] = mem_ready[p] ? mval[p] : $urandom;
            end
        end

        #1;

        for (int p = 0; p < 2; p++) begin
            m_ir[p] = (owner[p] == OWN_INST) && mem_ready[p];
            m_dr[p] = (owner[p] == OWN_DATA) && mem_ready[p];
            chk(tg(p, "mem_valid"), mem_valid[p], owner[p] != OWN_NONE);
            chk(tg(p, "state"), dbg_state[p], exp_state(owner[p]));
            if (owner[p] == OWN_INST) begin
                chk(tg(p, "inst_mem_addr"), mem_addr[p], inst_addr[p]);
                chk(tg(p, "inst_mem_we"), mem_we[p], 1'b0);
                chk(tg(p, "inst_mem_wstrb"), mem_wstrb[p], 4'h0);
                chk(tg(p, "inst_mem_wdata"), mem_wdata[p], 32'h0);
            end else if (owner[p] == OWN_DATA) begin
                chk(tg(p, "data_mem_addr"), mem_addr[p], data_addr[p]);
                chk(tg(p, "data_mem_we"), mem_we[p], data_we[p]);
                chk(tg(p, "data_mem_wstrb"), mem_wstrb[p], data_wstrb[p]);
                chk(tg(p, "data_mem_wdata"), mem_wdata[p], data_wdata[p]);
            end
            chk(tg(p, "inst_ready"), inst_ready[p], m_ir[p]);
            chk(tg(p, "data_ready"), data_ready[p], m_dr[p]);
            chk(tg(p, "inst_rdata"), inst_rdata[p], m_ir[p] ? mval[p] : 32'h0);
            chk(tg(p, "data_rdata"), data_rdata[p], m_dr[p] ? mval[p] : 32'h0);
`ifdef MEM_PORT_ARBITER_PERF_EN
            chk(tg(p, "inst_wait"), inst_wait[p], m_wait_i[p]);
            chk(tg(p, "data_wait"), data_wait[p], m_wait_d[p]);
`endif
            // Record what the requesters actually saw, before they move on.
            if (inst_ready[p]) begin
                inst_done_cnt[p]++;
                rec_irdata[p] = inst_rdata[p];
                if (gcnt[p] < 16) glog[p][gcnt[p]] = OWN_INST;
                gcnt[p]++;
            end
            if (data_ready[p]) begin
                data_done_cnt[p]++;
                rec_addr[p]  = mem_addr[p];
                rec_wdata[p] = mem_wdata[p];
                rec_we[p]    = mem_we[p];
                rec_wstrb[p] = mem_wstrb[p];
                if (gcnt[p] < 16) glog[p][gcnt[p]] = OWN_DATA;
                gcnt[p]++;
            end
            if (inst_ready[p]) begin
                if (keep[p]) inst_addr[p] = $urandom;
                else         inst_valid[p] = 1'b0;
            end
            if (data_ready[p]) begin
                if (keep[p]) begin
                    data_addr[p]  = $urandom;
                    data_wdata[p] = $urandom;
                    data_we[p]    = 1'($urandom_range(0, 1));
                    data_wstrb[p] = 4'($urandom_range(0, 15));
                end else begin
                    data_valid[p] = 1'b0;
                end
            end
        end
    endtask

    // Run cycles until requester completes; returns how many cycles it took.
    task automatic wait_done(input int p, input bit is_data, input int budget, output int n);
        int start;
        start = is_data ? data_done_cnt[p] : inst_done_cnt[p];
        n = 0;
        while (n < budget && (is_data ? data_done_cnt[p] : inst_done_cnt[p]) == start) begin
            cycle();
            n++;
        end
        chk(tg(p, "wait_done_timeout"), (is_data ? data_done_cnt[p] : inst_done_cnt[p]) != start, 1'b1);
    endtask

    task automatic do_reset(input int p);
        rst[p] = 1'b1;
        cycle();
        rst[p] = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int n;
        int d0;
        total = 0;
        bad   = 0;
        for (int p = 0; p < 2; p++) begin
            rst[p] = 1'b1;
            inst_addr[p] = '0; inst_valid[p] = 1'b0;
            data_addr[p] = '0; data_wdata[p] = '0; data_we[p] = 1'b0;
            data_wstrb[p] = '0; data_valid[p] = 1'b0;
            mem_ready[p] = 1'b0; mem_rdata[p] = '0;
            owner[p] = OWN_NONE; last[p] = OWN_INST;
            m_ir[p] = 1'b0; m_dr[p] = 1'b0; m_wait_i[p] = '0; m_wait_d[p] = '0;
            mcnt[p] = 0; mlat[p] = 0; mval[p] = '0;
            lat_inst[p] = -1; lat_data[p] = -1;
            fixed_en[p] = 1'b0; fixed_val[p] = '0; keep[p] = 1'b0;
            inst_done_cnt[p] = 0; data_done_cnt[p] = 0; gcnt[p] = 0;
            rec_irdata[p] = '0; rec_addr[p] = '0; rec_wdata[p] = '0;
            rec_we[p] = 1'b0; rec_wstrb[p] = '0;
        end
        cycle();
        cycle();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state.
        for (int p = 0; p < 2; p++) begin
            chk(tg(p, "reset_mem_valid"), mem_valid[p], 1'b0);
            chk(tg(p, "reset_inst_ready"), inst_ready[p], 1'b0);
            chk(tg(p, "reset_data_ready"), data_ready[p], 1'b0);
            chk(tg(p, "reset_state"), dbg_state[p], IDLE);
        end

        // Single fetch, memory answers 2 cycles after the request appears.
        lat_inst[0] = 2; fixed_en[0] = 1'b1; fixed_val[0] = 32'hDEAD_BEEF;
        d0 = data_done_cnt[0];
        inst_addr[0] = 32'h100; inst_valid[0] = 1'b1;
        cycle();
        chk("fetch_valid_rise", mem_valid[0], 1'b1);
        chk("fetch_addr", mem_addr[0], 32'h100);
        wait_done(0, 1'b0, 20, n);
        chk("fetch_latency", n, 2);
        chk("fetch_rdata", rec_irdata[0], 32'hDEAD_BEEF);
        chk("fetch_no_data_ready", data_done_cnt[0] - d0, 0);
        fixed_en[0] = 1'b0; lat_inst[0] = -1;
        cycle();

        // Store with partial byte enables.
        d0 = data_done_cnt[0];
        lat_data[0] = 1;
        data_addr[0] = 32'h2000; data_wdata[0] = 32'h1234_5678;
        data_we[0] = 1'b1; data_wstrb[0] = 4'b0011; data_valid[0] = 1'b1;
        wait_done(0, 1'b1, 20, n);
        chk("store_addr", rec_addr[0], 32'h2000);
        chk("store_wdata", rec_wdata[0], 32'h1234_5678);
        chk("store_we", rec_we[0], 1'b1);
        chk("store_wstrb", rec_wstrb[0], 4'b0011);
        for (int i = 0; i < 3; i++) cycle();
        chk("store_ready_once", data_done_cnt[0] - d0, 1);
        lat_data[0] = -1;

        // Conflict with fixed priority: data first, then fetch.
        gcnt[0] = 0;
        inst_addr[0] = 32'h300; inst_valid[0] = 1'b1;
        data_addr[0] = 32'h400; data_we[0] = 1'b0; data_wstrb[0] = 4'h0;
        data_valid[0] = 1'b1;
        for (int i = 0; i < 40 && gcnt[0] < 2; i++) cycle();
        chk("prio_count", gcnt[0], 2);
        chk("prio_first", glog[0][0], OWN_DATA);
        chk("prio_second", glog[0][1], OWN_INST);

        // Conflict with round-robin: both held busy for four transfers.
        do_reset(1);
        keep[1] = 1'b1; gcnt[1] = 0;
        inst_addr[1] = 32'h500; inst_valid[1] = 1'b1;
        data_addr[1] = 32'h600; data_wdata[1] = 32'h55; data_we[1] = 1'b1;
        data_wstrb[1] = 4'hF; data_valid[1] = 1'b1;
        for (int i = 0; i < 100 && gcnt[1] < 4; i++) cycle();
        keep[1] = 1'b0;
        chk("rr_count", gcnt[1] >= 4, 1'b1);
        chk("rr_0", glog[1][0], OWN_DATA);
        chk("rr_1", glog[1][1], OWN_INST);
        chk("rr_2", glog[1][2], OWN_DATA);
        chk("rr_3", glog[1][3], OWN_INST);
        for (int i = 0; i < 40 && (inst_valid[1] || data_valid[1]); i++) cycle();
        chk("rr_drained", inst_valid[1] || data_valid[1], 1'b0);

        // Reset while a load is in flight.
        d0 = data_done_cnt[0];
        lat_data[0] = 6;
        data_addr[0] = 32'h700; data_we[0] = 1'b0; data_wstrb[0] = 4'h0;
        data_valid[0] = 1'b1;
        cycle();
        cycle();
        chk("midrst_busy", dbg_state[0], BUSY_DATA);
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        data_valid[0] = 1'b0;
        chk("midrst_valid_low", mem_valid[0], 1'b0);
        chk("midrst_state", dbg_state[0], IDLE);
        for (int i = 0; i < 4; i++) cycle();
        chk("midrst_no_ready", data_done_cnt[0] - d0, 0);
        lat_data[0] = -1;

        // Fetch waits behind a zero-latency load, then its own 2 cycles.
        do_reset(0);
        gcnt[0] = 0;
        lat_data[0] = 0; lat_inst[0] = 2;
        inst_addr[0] = 32'h800; inst_valid[0] = 1'b1;
        data_addr[0] = 32'h900; data_we[0] = 1'b0; data_valid[0] = 1'b1;
        for (int i = 0; i < 30 && gcnt[0] < 2; i++) cycle();
        chk("perf_order_0", glog[0][0], OWN_DATA);
        chk("perf_order_1", glog[0][1], OWN_INST);
`ifdef MEM_PORT_ARBITER_PERF_EN
        chk("perf_inst_wait", inst_wait[0], 32'd5);
        chk("perf_data_wait", data_wait[0], 32'd1);
`endif
        lat_data[0] = -1; lat_inst[0] = -1;
        cycle();

        // Random traffic on both arbiters.
        d0 = inst_done_cnt[0] + data_done_cnt[0] + inst_done_cnt[1] + data_done_cnt[1];
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!inst_valid[p] && $urandom_range(0, 2) == 0) begin
                    inst_valid[p] = 1'b1;
                    inst_addr[p]  = $urandom;
                end
                if (!data_valid[p] && $urandom_range(0, 2) == 0) begin
                    data_valid[p] = 1'b1;
                    data_addr[p]  = $urandom;
                    data_wdata[p] = $urandom;
                    data_we[p]    = 1'($urandom_range(0, 1));
                    data_wstrb[p] = 4'($urandom_range(0, 15));
                end
            end
            cycle();
        end
        for (int i = 0; i < 60 && (inst_valid[0] || data_valid[0] || inst_valid[1] || data_valid[1]); i++) cycle();
        chk("rand_drained", inst_valid[0] || data_valid[0] || inst_valid[1] || data_valid[1], 1'b0);
        chk("rand_progress",
            (inst_done_cnt[0] + data_done_cnt[0] + inst_done_cnt[1] + data_done_cnt[1] - d0) > 100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
